// File: rtl/cu_engine_s_axi_responder_pkg.sv
// Shared types and AXI encodings for the CU engine AXI4 responder.
// One-hot FSM state encoding plus response/burst constants.
package cu_engine_s_axi_responder_pkg;

  typedef enum logic [4:0] {
    CU_ENGINE_S_AXI_RESET = 5'b00001,
    CU_ENGINE_S_AXI_IDLE  = 5'b00010,
    CU_ENGINE_S_AXI_READ  = 5'b00100,
    CU_ENGINE_S_AXI_WRITE = 5'b01000,
    CU_ENGINE_S_AXI_RESP  = 5'b10000
  } cu_engine_s_axi_state;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  function automatic logic [1:0] axi_resp_of(input logic err);
    return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/cu_engine_s_axi_ram.sv
// Simple dual-port word RAM: byte-enabled write port, registered read port.
// Read data appears the cycle after re and holds while re is low.
module cu_engine_s_axi_ram #(
  parameter int DATA_W     = 512,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cu_engine_s_axi_responder.sv
// AXI4 slave serving one INCR burst at a time from a word RAM; CU_ENGINE_S_AXI_WSTRB_EN enables byte strobes.
// R: first beat 2 cycles after AR, advances only on !rvalid||rready; W: wready 1 cycle after AW, bvalid 1 cycle after last beat.
module cu_engine_s_axi_responder
  import cu_engine_s_axi_responder_pkg::*;
#(
  parameter int DATA_W     = 512,
  parameter int ADDR_W     = 64,
  parameter int ID_W       = 1,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [7:0]          s_axi_arlen,
  input  logic [1:0]          s_axi_arburst,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [7:0]          s_axi_awlen,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFFS   = $clog2(STRB_W);

  cu_engine_s_axi_state state, state_nxt;

  logic                  prefer_read;
  logic [ID_W-1:0]       cur_id;
  logic [7:0]            cur_len;
  logic                  burst_err;
  logic                  wlast_err;
  logic [7:0]            beat_cnt;
  logic [8:0]            issue_cnt;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  rvalid_q;

  logic ar_hs, aw_hs, w_hs, r_hs, rd_issue, w_final, both_vld;

  logic                  ram_we, ram_re;
  logic [STRB_W-1:0]     ram_wbe;
  logic [DATA_W-1:0]     ram_rdata;

  // Only a simultaneous AR/AW request makes one ready depend on the other valid.
  assign both_vld = s_axi_arvalid && s_axi_awvalid;
  assign ar_hs    = (state == CU_ENGINE_S_AXI_IDLE) && s_axi_arvalid && (!s_axi_awvalid || prefer_read);
  assign aw_hs    = (state == CU_ENGINE_S_AXI_IDLE) && s_axi_awvalid && (!s_axi_arvalid || !prefer_read);
  assign w_hs     = (state == CU_ENGINE_S_AXI_WRITE) && s_axi_wvalid;
  assign r_hs     = rvalid_q && s_axi_rready;
  assign w_final  = (beat_cnt == cur_len);

  // Reads run ahead of the R channel by at most the one beat held in the RAM output register.
  assign rd_issue = (state == CU_ENGINE_S_AXI_READ)
                 && (issue_cnt != ({1'b0, cur_len} + 9'd1))
                 && (!rvalid_q || s_axi_rready);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= CU_ENGINE_S_AXI_RESET;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (state)
      CU_ENGINE_S_AXI_RESET: state_nxt = CU_ENGINE_S_AXI_IDLE;
      CU_ENGINE_S_AXI_IDLE: begin
        s_axi_arready = !both_vld || prefer_read;
        s_axi_awready = !both_vld || !prefer_read;
        if (ar_hs)      state_nxt = CU_ENGINE_S_AXI_READ;
        else if (aw_hs) state_nxt = CU_ENGINE_S_AXI_WRITE;
      end
      CU_ENGINE_S_AXI_READ: begin
        if (r_hs && s_axi_rlast) state_nxt = CU_ENGINE_S_AXI_IDLE;
      end
      CU_ENGINE_S_AXI_WRITE: begin
        s_axi_wready = 1'b1;
        if (w_hs && w_final) state_nxt = CU_ENGINE_S_AXI_RESP;
      end
      CU_ENGINE_S_AXI_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) state_nxt = CU_ENGINE_S_AXI_IDLE;
      end
      default: state_nxt = CU_ENGINE_S_AXI_RESET;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prefer_read <= 1'b1;
      cur_id      <= '0;
      cur_len     <= '0;
      burst_err   <= 1'b0;
      wlast_err   <= 1'b0;
      beat_cnt    <= '0;
      issue_cnt   <= '0;
      idx         <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      if (ar_hs) begin
        prefer_read <= 1'b0;
        cur_id      <= s_axi_arid;
        cur_len     <= s_axi_arlen;
        burst_err   <= (s_axi_arburst != AXI_BURST_INCR);
        wlast_err   <= 1'b0;
        beat_cnt    <= '0;
        issue_cnt   <= '0;
        idx         <= s_axi_araddr[OFFS +: DEPTH_LOG2];
      end else if (aw_hs) begin
        prefer_read <= 1'b1;
        cur_id      <= s_axi_awid;
        cur_len     <= s_axi_awlen;
        burst_err   <= (s_axi_awburst != AXI_BURST_INCR);
        wlast_err   <= 1'b0;
        beat_cnt    <= '0;
        issue_cnt   <= '0;
        idx         <= s_axi_awaddr[OFFS +: DEPTH_LOG2];
      end
      if (rd_issue) begin
        idx       <= idx + 1'b1;
        issue_cnt <= issue_cnt + 9'd1;
      end
      if (w_hs) begin
        idx      <= idx + 1'b1;
        beat_cnt <= beat_cnt + 8'd1;
        if (s_axi_wlast != w_final) wlast_err <= 1'b1;
      end
      if (r_hs) beat_cnt <= beat_cnt + 8'd1;
      if (rd_issue)  rvalid_q <= 1'b1;
      else if (r_hs) rvalid_q <= 1'b0;
    end
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rlast  = rvalid_q && w_final;
  assign s_axi_rdata  = (rvalid_q && !burst_err) ? ram_rdata : '0;
  assign s_axi_rid    = rvalid_q ? cur_id : '0;
  assign s_axi_rresp  = rvalid_q ? axi_resp_of(burst_err) : AXI_RESP_OKAY;
  assign s_axi_bid    = s_axi_bvalid ? cur_id : '0;
  assign s_axi_bresp  = s_axi_bvalid ? axi_resp_of(burst_err || wlast_err) : AXI_RESP_OKAY;

  // Erroneous bursts still count beats but never touch the RAM.
  assign ram_we = w_hs && !burst_err;
  assign ram_re = rd_issue && !burst_err;

`ifdef CU_ENGINE_S_AXI_WSTRB_EN
  assign ram_wbe = s_axi_wstrb;
`else
  assign ram_wbe = '1;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_araddr[ADDR_W-1:OFFS+DEPTH_LOG2], s_axi_araddr[OFFS-1:0],
                           s_axi_awaddr[ADDR_W-1:OFFS+DEPTH_LOG2], s_axi_awaddr[OFFS-1:0],
                           s_axi_wstrb};

  cu_engine_s_axi_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (ap_clk),
    .we    (ram_we),
    .waddr (idx),
    .wdata (s_axi_wdata),
    .wbe   (ram_wbe),
    .re    (ram_re),
    .raddr (idx),
    .rdata (ram_rdata)
  );

endmodule
